bp_me_wb_arbiter: RTL and testbench
===================================

// Module: bp_me_wb_arbiter
// PURPOSE
//  Round-robin arbiter sharing one Wishbone B4 (classic) slave port among num_masters_p masters,
//  e.g. several bp_me_wb_master bridges (per-core uncached paths) feeding one peripheral bus.
//  Grants whole bus cycles (cyc held), routes ack/data back to the granted master only.
//  Supports an optional watchdog that terminates hung slave cycles.
// PARAMETERS
//  num_masters_p     2     number of WB masters (>=1)
//  adr_width_p       37    WB word-address width (paddr_width_p - log2(data_width_p/8))
//  data_width_p      64    WB data width; sel width = data_width_p/8
//  timeout_cycles_p  1024  watchdog limit, cycles of stb without ack (used only with macro)
// PORTS
//  clk_i        in   1                   clock
//  reset_i      in   1                   async active-high reset
//  m_adr_i      in   num*adr_width_p     master addresses, master k at slice k
//  m_dat_i      in   num*data_width_p    master write data
//  m_sel_i      in   num*data_width_p/8  master byte selects
//  m_we_i       in   num                 master write enables
//  m_cyc_i      in   num                 master cycle requests
//  m_stb_i      in   num                 master strobes
//  m_dat_o      out  data_width_p        read data, broadcast to all masters
//  m_ack_o      out  num                 per-master ack, only granted bit may be 1
//  s_adr_o/s_dat_o/s_sel_o/s_we_o  out   slave-side copies of granted master's signals
//  s_cyc_o      out  1                   slave cycle
//  s_stb_o      out  1                   slave strobe
//  s_dat_i      in   data_width_p        slave read data
//  s_ack_i      in   1                   slave ack
//  grant_id_o   out  clog2(num)          index of granted master (valid when busy)
//  timeout_o    out  1                   1-cycle pulse on watchdog expiry; tied 0 without macro
// BEHAVIOUR
//  - Reset (async): state=e_idle, grant_r=0, rr_ptr_r=0, cnt_r=0; s_cyc_o=s_stb_o=0, m_ack_o=0,
//    grant_id_o=0, timeout_o=0. Reset mid-cycle drops s_cyc_o/s_stb_o immediately.
//  - FSM e_idle: s_cyc_o=s_stb_o=0. If any m_cyc_i: grant_r <= first k with m_cyc_i[k], searching
//    rr_ptr_r, rr_ptr_r+1, ... mod num; -> e_busy. Arbitration latency: 1 cycle.
//  - e_busy: slave outputs combinationally muxed from master grant_r; s_cyc_o=m_cyc_i[grant_r],
//    s_stb_o=m_stb_i[grant_r]. m_ack_o[grant_r]=s_ack_i; all other acks 0. m_dat_o=s_dat_i.
//  - Release: in e_busy when m_cyc_i[grant_r]==0 (normal after ack, or abort without ack):
//    -> e_idle, rr_ptr_r <= (grant_r+1) mod num. One idle cycle always separates grants.
//  - Multiple beats within one held cyc stay with the same master (no preemption).
//  - s_ack_i while e_idle is ignored (no m_ack_o).
//  - num_masters_p=1: rr_ptr stays 0; grant_id_o width is 1 (safe clog2).
//  - Non-granted masters see no ack and simply wait with cyc/stb held.
// CONFIGURATION
//  - Macro BP_ME_WB_ARBITER_TIMEOUT_EN defined: cnt_r increments each e_busy cycle with s_stb_o & ~s_ack_i,
//    clears on s_ack_i or leaving e_busy. When cnt_r==timeout_cycles_p-1 and no s_ack_i this cycle:
//    m_ack_o[grant_r]=1 with m_dat_o all ones for that cycle, timeout_o pulses 1, state -> e_abort.
//    e_abort: s_cyc_o=s_stb_o=0, m_ack_o=0; -> e_idle (rr rotate) when m_cyc_i[grant_r]==0.
//    Real s_ack_i in the expiry cycle wins: normal ack, no timeout, cnt_r cleared.
//  - Macro undefined: no counter, no e_abort; timeout_o tied 0; hung slave blocks bus forever.
// TESTING
//  1 Single master 0 read, slave acks after 3 cycles with 'hDEAD -> s_cyc_o rises 1 cycle after
//    m_cyc_i[0], m_ack_o=2'b01 for 1 cycle, m_dat_o='hDEAD, idle cycle, rr_ptr=1.
//  2 Masters 0,1 request same cycle from reset -> master 0 granted first, master 1 granted one
//    idle cycle after master 0 drops cyc; m_ack_o[1] never 1 during master 0 cycle.
//  3 Both masters request continuously, 6 transactions -> grant order 0,1,0,1,0,1.
//  4 Master 1 write adr='h10 sel='hFF dat='h1234 -> slave observes same adr/sel/dat/we=1 while busy.
//  5 Granted master drops cyc without ack; spurious s_ack_i in following idle cycle -> s_cyc_o
//    drops same cycle, no m_ack_o asserted, next request granted normally.
//  6 (TIMEOUT_EN, timeout_cycles_p=8) slave never acks -> after 8 stb cycles m_ack_o pulses once,
//    m_dat_o all ones, timeout_o=1 one cycle, s_cyc_o=0 until master releases; reset mid-abort -> idle.

Source files
------------

// File: rtl/bp_me_wb_arbiter.sv
// Round-robin arbiter that shares one Wishbone B4 classic slave port among
// num_masters_p masters. A grant covers a whole bus cycle (while cyc is held).
// Ack and read data are routed back to the granted master only.
// Optional watchdog: define BP_ME_WB_ARBITER_TIMEOUT_EN to terminate slave
// cycles that stay unacknowledged for timeout_cycles_p strobe cycles.
module bp_me_wb_arbiter #(
    parameter int num_masters_p    = 2,
    parameter int adr_width_p      = 37,
    parameter int data_width_p     = 64,
    parameter int timeout_cycles_p = 1024,
    localparam int sel_width_lp    = data_width_p / 8,
    localparam int grant_width_lp  = (num_masters_p > 1) ? $clog2(num_masters_p) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [num_masters_p*adr_width_p-1:0]    m_adr_i,
    input  logic [num_masters_p*data_width_p-1:0]   m_dat_i,
    input  logic [num_masters_p*sel_width_lp-1:0]   m_sel_i,
    input  logic [num_masters_p-1:0]                m_we_i,
    input  logic [num_masters_p-1:0]                m_cyc_i,
    input  logic [num_masters_p-1:0]                m_stb_i,
    output logic [data_width_p-1:0]                 m_dat_o,
    output logic [num_masters_p-1:0]                m_ack_o,
    output logic [adr_width_p-1:0]                  s_adr_o,
    output logic [data_width_p-1:0]                 s_dat_o,
    output logic [sel_width_lp-1:0]                 s_sel_o,
    output logic                                    s_we_o,
    output logic                                    s_cyc_o,
    output logic                                    s_stb_o,
    input  logic [data_width_p-1:0]                 s_dat_i,
    input  logic                                    s_ack_i,
    output logic [grant_width_lp-1:0]               grant_id_o,
    output logic                                    timeout_o
);

    typedef enum logic [1:0] {e_idle, e_busy, e_abort} state_e;

    state_e                     state_q, state_d;
    logic [grant_width_lp-1:0]  grant_q, grant_d;
    logic [grant_width_lp-1:0]  rr_ptr_q, rr_ptr_d;

    // Per-master views of the flattened input buses
    logic [adr_width_p-1:0]     adr_arr  [num_masters_p];
    logic [data_width_p-1:0]    dat_arr  [num_masters_p];
    logic [sel_width_lp-1:0]    sel_arr  [num_masters_p];

    for (genvar gi = 0; gi < num_masters_p; gi++) begin : g_unpack
        assign adr_arr[gi] = m_adr_i[gi*adr_width_p +: adr_width_p];
        assign dat_arr[gi] = m_dat_i[gi*data_width_p +: data_width_p];
        assign sel_arr[gi] = m_sel_i[gi*sel_width_lp +: sel_width_lp];
    end

    logic gnt_cyc;
    logic gnt_stb;
    assign gnt_cyc = m_cyc_i[grant_q];
    assign gnt_stb = m_stb_i[grant_q];

    // Master after the current grant, wrapping; becomes the new search start on release
    logic [grant_width_lp-1:0] next_ptr;
    assign next_ptr = (grant_q == grant_width_lp'(num_masters_p - 1)) ? '0 : grant_q + 1'b1;

    // Round-robin search: first requester at or after rr_ptr_q
    logic                       pick_found;
    logic [grant_width_lp-1:0]  pick_idx;
    logic [31:0]                pick_cand;
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_cand  = '0;
        for (int i = 0; i < num_masters_p; i++) begin
            pick_cand = (32'(rr_ptr_q) + 32'(i)) % 32'(num_masters_p);
            if (!pick_found && m_cyc_i[pick_cand[grant_width_lp-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = pick_cand[grant_width_lp-1:0];
            end
        end
    end

`ifdef BP_ME_WB_ARBITER_TIMEOUT_EN
    localparam int cnt_width_lp = $clog2(timeout_cycles_p) + 1;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic                    expire;

    // Watchdog fires on the last allowed strobe cycle unless the slave acks in it
    assign expire = (state_q == e_busy) && gnt_cyc && gnt_stb && !s_ack_i
                    && (cnt_q == cnt_width_lp'(timeout_cycles_p - 1));

    // Count strobe cycles awaiting ack; any ack, expiry or leaving busy clears it
    always_comb begin
        cnt_d = '0;
        if ((state_q == e_busy) && gnt_cyc && gnt_stb && !s_ack_i && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unused_timeout_lp = timeout_cycles_p;
    logic expire;
    assign expire = 1'b0;
`endif

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= e_idle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state: grant from idle, release when the owner drops cyc
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            e_idle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = e_busy;
                end
            end
            e_busy: begin
                if (!gnt_cyc) begin
                    state_d  = e_idle;
                    rr_ptr_d = next_ptr;
                end else if (expire) begin
                    state_d = e_abort;
                end
            end
            e_abort: begin
                if (!gnt_cyc) begin
                    state_d  = e_idle;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    // Outputs: slave side muxed from the grant, ack/data routed to the grant
    always_comb begin
        s_adr_o   = adr_arr[grant_q];
        s_dat_o   = dat_arr[grant_q];
        s_sel_o   = sel_arr[grant_q];
        s_we_o    = m_we_i[grant_q];
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m_ack_o   = '0;
        m_dat_o   = s_dat_i;
        timeout_o = 1'b0;
        if (state_q == e_busy) begin
            s_cyc_o          = gnt_cyc;
            s_stb_o          = gnt_stb;
            m_ack_o[grant_q] = s_ack_i;
            if (expire) begin
                m_ack_o[grant_q] = 1'b1;
                m_dat_o          = '1;
                timeout_o        = 1'b1;
            end
        end
    end

    assign grant_id_o = grant_q;

endmodule

// File: tb/tb_bp_me_wb_arbiter.sv
// Self-checking bench for bp_me_wb_arbiter: directed scenarios followed by
// randomized traffic checked against a transaction-level ownership model.
// The watchdog scenario runs only when BP_ME_WB_ARBITER_TIMEOUT_EN is defined.
module tb_bp_me_wb_arbiter;

    localparam int N  = 2;
    localparam int AW = 37;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [N*AW-1:0]   m_adr_i;
    logic [N*DW-1:0]   m_dat_i;
    logic [N*SW-1:0]   m_sel_i;
    logic [N-1:0]      m_we_i;
    logic [N-1:0]      m_cyc_i;
    logic [N-1:0]      m_stb_i;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i;
    logic [0:0]        grant_id_o;
    logic              timeout_o;

    logic [AW-1:0]     tb_adr [N];
    logic [DW-1:0]     tb_dat [N];
    logic [SW-1:0]     tb_sel [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign m_adr_i[gi*AW +: AW] = tb_adr[gi];
        assign m_dat_i[gi*DW +: DW] = tb_dat[gi];
        assign m_sel_i[gi*SW +: SW] = tb_sel[gi];
    end

    bp_me_wb_arbiter #(
        .num_masters_p   (N),
        .adr_width_p     (AW),
        .data_width_p    (DW),
        .timeout_cycles_p(TO)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_we_i    (m_we_i),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .grant_id_o(grant_id_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int k, input logic cyc, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel);
        m_cyc_i[k] = cyc;
        m_stb_i[k] = cyc;
        m_we_i[k]  = we;
        tb_adr[k]  = adr;
        tb_dat[k]  = dat;
        tb_sel[k]  = sel;
    endtask

    task automatic drop_m(input int k);
        m_cyc_i[k] = 1'b0;
        m_stb_i[k] = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        s_ack_i = 1'b0;
        s_dat_i = '0;
        for (int k = 0; k < N; k++) set_m(k, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        reset_i = 1'b0;
    endtask

    // Slave acks now; master k must see the ack and data, then drops cyc after the edge
    task automatic finish_txn(input int k, input logic [DW-1:0] dat, input string tag);
        s_ack_i = 1'b1;
        s_dat_i = dat;
        #1;
        chk({tag, "_ack"}, m_ack_o, N'(1) << k);
        chk({tag, "_rdata"}, m_dat_o, dat);
        @(posedge clk); #1;
        s_ack_i = 1'b0;
        drop_m(k);
    endtask

    // Random-phase model state
    int          owner;
    int          ptr;
    int          cand;
    int          beats [N];
    int          wait_cnt;
    int          w;
    logic [N-1:0] acked;
    logic [63:0] rnd;

    initial begin
        do_reset();
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_s_cyc", s_cyc_o, 1'b0);
        chk("rst_s_stb", s_stb_o, 1'b0);
        chk("rst_m_ack", m_ack_o, 2'b00);
        chk("rst_grant", grant_id_o, 1'b0);
        chk("rst_timeout", timeout_o, 1'b0);

        // 1: single master read, 1-cycle arbitration latency, ack after 3 busy cycles
        @(posedge clk); #1;
        set_m(0, 1'b1, 1'b0, 37'h100, '0, 8'hFF);
        @(negedge clk);
        chk("t1_latency_cyc", s_cyc_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_busy_cyc", s_cyc_o, 1'b1);
        chk("t1_busy_stb", s_stb_o, 1'b1);
        chk("t1_grant", grant_id_o, 1'b0);
        chk("t1_s_adr", s_adr_o, 37'h100);
        chk("t1_wait_ack", m_ack_o, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_wait_ack", m_ack_o, 2'b00);
        @(posedge clk); #1;
        finish_txn(0, 64'hDEAD, "t1");
        #1;
        chk("t1_drop_cyc", s_cyc_o, 1'b0);
        chk("t1_drop_ack", m_ack_o, 2'b00);
        @(posedge clk); #1;
        // Both request now; rr pointer moved to 1 so master 1 wins
        set_m(0, 1'b1, 1'b0, 37'h1, '0, 8'h01);
        set_m(1, 1'b1, 1'b0, 37'h2, '0, 8'h02);
        @(negedge clk);
        chk("t1_idle_gap", s_cyc_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_rr_ptr", grant_id_o, 1'b1);
        chk("t1_rr_adr", s_adr_o, 37'h2);

        // 2/3: both request from reset, continuously; order 0,1,0,1,0,1
        do_reset();
        set_m(0, 1'b1, 1'b0, 37'hA0, '0, 8'hFF);
        set_m(1, 1'b1, 1'b0, 37'hB0, '0, 8'hFF);
        for (int t = 0; t < 6; t++) begin
            w = 0;
            @(negedge clk);
            while (s_cyc_o !== 1'b1 && w < 10) begin
                @(negedge clk);
                w++;
            end
            chk("t3_idle_gap", w, 1);
            chk("t3_order", grant_id_o, t % 2);
            chk("t2_no_early_ack", m_ack_o, 2'b00);
            finish_txn(t % 2, 64'(t + 'h50), "t3");
            @(posedge clk); #1;
            set_m(t % 2, 1'b1, 1'b0, (t % 2 == 0) ? 37'hA0 : 37'hB0, '0, 8'hFF);
        end

        // 4: master 1 write routed to slave
        do_reset();
        set_m(1, 1'b1, 1'b1, 37'h10, 64'h1234, 8'hFF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_grant", grant_id_o, 1'b1);
        chk("t4_s_adr", s_adr_o, 37'h10);
        chk("t4_s_sel", s_sel_o, 8'hFF);
        chk("t4_s_dat", s_dat_o, 64'h1234);
        chk("t4_s_we", s_we_o, 1'b1);
        finish_txn(1, 64'h0, "t4");

        // 5: abort without ack, spurious ack while idle, then normal grant
        do_reset();
        set_m(0, 1'b1, 1'b0, 37'h20, '0, 8'h0F);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_busy_cyc", s_cyc_o, 1'b1);
        @(posedge clk); #1;
        drop_m(0);
        #1;
        chk("t5_abort_cyc", s_cyc_o, 1'b0);
        chk("t5_abort_ack", m_ack_o, 2'b00);
        @(posedge clk); #1;
        s_ack_i = 1'b1;
        #1;
        chk("t5_spurious_ack", m_ack_o, 2'b00);
        @(posedge clk); #1;
        s_ack_i = 1'b0;
        set_m(0, 1'b1, 1'b0, 37'h24, '0, 8'h0F);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_regrant_cyc", s_cyc_o, 1'b1);
        chk("t5_regrant_id", grant_id_o, 1'b0);
        finish_txn(0, 64'hBEEF, "t5");

        // Reset mid-cycle drops the slave cycle at once
        @(posedge clk); #1;
        set_m(1, 1'b1, 1'b0, 37'h30, '0, 8'h01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_busy", s_cyc_o, 1'b1);
        reset_i = 1'b1;
        #1;
        chk("rst_mid_cyc", s_cyc_o, 1'b0);
        chk("rst_mid_grant", grant_id_o, 1'b0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        drop_m(1);

`ifdef BP_ME_WB_ARBITER_TIMEOUT_EN
        // 6: slave never acks; watchdog terminates after TO strobe cycles
        do_reset();
        set_m(0, 1'b1, 1'b0, 37'h40, '0, 8'hFF);
        @(posedge clk); #1;
        for (int c = 1; c < TO; c++) begin
            @(negedge clk);
            chk("t6_pre_ack", m_ack_o, 2'b00);
            chk("t6_pre_timeout", timeout_o, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t6_ack", m_ack_o, 2'b01);
        chk("t6_rdata_ones", m_dat_o, {DW{1'b1}});
        chk("t6_timeout", timeout_o, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_abort_cyc", s_cyc_o, 1'b0);
        chk("t6_abort_ack", m_ack_o, 2'b00);
        chk("t6_abort_timeout", timeout_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_abort_hold", s_cyc_o, 1'b0);
        reset_i = 1'b1;
        #1;
        chk("t6_rst_cyc", s_cyc_o, 1'b0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("t6_rst_idle", s_cyc_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_regrant", s_cyc_o, 1'b1);
        finish_txn(0, 64'h77, "t6");
`endif

        // Random traffic against an ownership model
        do_reset();
        owner    = -1;
        ptr      = 0;
        wait_cnt = 0;
        for (int k = 0; k < N; k++) beats[k] = 0;
        for (int cyc_n = 0; cyc_n < 1500; cyc_n++) begin
            @(negedge clk);
            if (owner >= 0) begin
                chk("rnd_s_cyc", s_cyc_o, m_cyc_i[owner]);
                chk("rnd_s_stb", s_stb_o, m_stb_i[owner]);
                chk("rnd_grant", grant_id_o, owner);
                chk("rnd_s_adr", s_adr_o, tb_adr[owner]);
                chk("rnd_s_dat", s_dat_o, tb_dat[owner]);
                chk("rnd_s_we", s_we_o, m_we_i[owner]);
                chk("rnd_m_ack", m_ack_o, s_ack_i ? (N'(1) << owner) : N'(0));
                chk("rnd_m_dat", m_dat_o, s_dat_i);
            end else begin
                chk("rnd_idle_cyc", s_cyc_o, 1'b0);
                chk("rnd_idle_ack", m_ack_o, 2'b00);
            end
            chk("rnd_timeout", timeout_o, 1'b0);
            for (int k = 0; k < N; k++) acked[k] = (owner == k) && s_ack_i;

            @(posedge clk);
            if (owner < 0) begin
                for (int i = 0; i < N; i++) begin
                    cand = (ptr + i) % N;
                    if (owner < 0 && m_cyc_i[cand]) owner = cand;
                end
            end else if (!m_cyc_i[owner]) begin
                ptr   = (owner + 1) % N;
                owner = -1;
            end
            #1;

            for (int k = 0; k < N; k++) begin
                rnd = {$urandom(), $urandom()};
                if (acked[k]) begin
                    beats[k]--;
                    if (beats[k] == 0) drop_m(k);
                    else set_m(k, 1'b1, rnd[0], rnd[AW-1:0], {rnd[31:0], rnd[63:32]}, rnd[15:8]);
                end else if (!m_cyc_i[k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_m(k, 1'b1, rnd[1], rnd[AW-1:0], rnd, rnd[23:16]);
                        beats[k] = $urandom_range(1, 3);
                    end
                end else if (owner == k && $urandom_range(0, 39) == 0) begin
                    drop_m(k);
                end
            end
            if (s_ack_i) begin
                s_ack_i  = 1'b0;
                wait_cnt = $urandom_range(0, 4);
            end else if (owner >= 0 && m_cyc_i[owner] && m_stb_i[owner]) begin
                if (wait_cnt == 0) begin
                    s_ack_i = 1'b1;
                    s_dat_i = {$urandom(), $urandom()};
                end else begin
                    wait_cnt--;
                end
            end else if (owner < 0) begin
                s_ack_i = ($urandom_range(0, 7) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
